// File: rtl/counter_updown_param_pkg.sv
// Shared constants for the parametrised up/down counter family.
// MODE_* select the end-of-range behaviour.
package counter_updown_param_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with wrap/saturate mode, synchronous load,
// terminal-count pulse and a sticky overflow flag.
module counter_updown_param
  import counter_updown_param_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int RST_VAL = 0,
  parameter int MODE    = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  // Parameter ranges are rejected at elaboration rather than silently truncated.
  if (WIDTH < 2 || WIDTH > 31) begin : g_badWidth
    $error("counter_updown_param: WIDTH must be in 2..31");
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_badMax
    $error("counter_updown_param: MAX_VAL out of range for WIDTH");
  end
  if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_badRst
    $error("counter_updown_param: RST_VAL must lie in 0..MAX_VAL");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_badMode
    $error("counter_updown_param: MODE must be MODE_WRAP or MODE_SAT");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextTc;
  logic             w_satEvent;
  logic             w_nextOvf;
  logic             w_atMax;
  logic             w_atZero;

  assign w_atMax  = (r_count == MAX_C);
  assign w_atZero = (r_count == '0);

  always_comb begin
    w_nextCount = r_count;
    w_nextTc    = 1'b0;
    w_satEvent  = 1'b0;
    if (load) begin
      w_nextCount = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (dir) begin
        if (!w_atMax) begin
          w_nextCount = r_count + WIDTH'(1);
        end else if (MODE == MODE_SAT) begin
          w_satEvent = 1'b1;
        end else begin
          w_nextCount = '0;
          w_nextTc    = 1'b1;
        end
      end else begin
        if (!w_atZero) begin
          w_nextCount = r_count - WIDTH'(1);
        end else if (MODE == MODE_SAT) begin
          w_satEvent = 1'b1;
        end else begin
          w_nextCount = MAX_C;
          w_nextTc    = 1'b1;
        end
      end
    end
  end

  // A saturation event in the same cycle as clr_ovf keeps the flag set.
  assign w_nextOvf = w_satEvent | (r_ovf & ~clr_ovf);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_C;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_tc    <= w_nextTc;
      r_ovf   <= w_nextOvf;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign ovf     = r_ovf;
  assign at_max  = w_atMax;
  assign at_zero = w_atZero;

endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench for counter_updown_param: an 8-bit wrap instance plus
// 4-bit (MAX_VAL=9) wrap and saturate instances driven by directed steps.
module tb_counter_updown_param;
  import counter_updown_param_pkg::*;

  typedef struct {
    int         inst;
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
    logic       atMax;
    logic       atZero;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] en;
  logic [2:0] dir;
  logic [2:0] load;
  logic [2:0] clrOvf;
  logic [7:0] loadVal [3];

  logic [7:0] cnt0;
  logic [3:0] cnt1, cnt2;
  logic [2:0] tcV, ovfV, atMaxV, atZeroV;

  exp_t sbq[$];
  int   mCnt [3];
  bit   mOvf [3];
  int   maxVal [3] = '{255, 9, 9};
  int   rstVal [3] = '{0, 0, 2};
  int   modeV  [3] = '{MODE_WRAP, MODE_WRAP, MODE_SAT};
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  counter_updown_param #(.WIDTH(8), .MAX_VAL(255), .RST_VAL(0), .MODE(MODE_WRAP)) dut0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .dir(dir[0]), .load(load[0]),
    .load_val(loadVal[0]), .clr_ovf(clrOvf[0]), .count(cnt0), .tc(tcV[0]),
    .ovf(ovfV[0]), .at_max(atMaxV[0]), .at_zero(atZeroV[0]));

  counter_updown_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0), .MODE(MODE_WRAP)) dut1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .dir(dir[1]), .load(load[1]),
    .load_val(loadVal[1][3:0]), .clr_ovf(clrOvf[1]), .count(cnt1), .tc(tcV[1]),
    .ovf(ovfV[1]), .at_max(atMaxV[1]), .at_zero(atZeroV[1]));

  counter_updown_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(2), .MODE(MODE_SAT)) dut2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .dir(dir[2]), .load(load[2]),
    .load_val(loadVal[2][3:0]), .clr_ovf(clrOvf[2]), .count(cnt2), .tc(tcV[2]),
    .ovf(ovfV[2]), .at_max(atMaxV[2]), .at_zero(atZeroV[2]));

  initial $monitor("[TB] t=%0t sat count=%b (%0d) tc=%b ovf=%b", $time, cnt2, cnt2, tcV[2], ovfV[2]);

  // Pop the oldest expectation and compare every output of that instance.
  task automatic checkOutput();
    exp_t       e;
    logic [7:0] c;
    if (sbq.size() == 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL scoreboard empty");
      return;
    end
    e = sbq.pop_front();
    c = (e.inst == 0) ? cnt0 : (e.inst == 1) ? {4'b0, cnt1} : {4'b0, cnt2};
    testCount++;
    assert (c === e.cnt) else begin
      failCount++;
      $error("[TB] FAIL count[%0d] observed=%0d expected=%0d", e.inst, c, e.cnt);
    end
    testCount++;
    assert (tcV[e.inst] === e.tc) else begin
      failCount++;
      $error("[TB] FAIL tc[%0d] observed=%b expected=%b (count=%0d)", e.inst, tcV[e.inst], e.tc, c);
    end
    testCount++;
    assert (ovfV[e.inst] === e.ovf) else begin
      failCount++;
      $error("[TB] FAIL ovf[%0d] observed=%b expected=%b (count=%0d)", e.inst, ovfV[e.inst], e.ovf, c);
    end
    testCount++;
    assert ({atMaxV[e.inst], atZeroV[e.inst]} === {e.atMax, e.atZero}) else begin
      failCount++;
      $error("[TB] FAIL flags[%0d] observed=%b%b expected=%b%b (count=%0d)", e.inst,
             atMaxV[e.inst], atZeroV[e.inst], e.atMax, e.atZero, c);
    end
  endtask

  // Drive one instance for one edge; the others hold. Expected state is pushed before the edge.
  task automatic applyStimulus(input int k, input bit r, input bit e, input bit d,
                               input bit l, input int lv, input bit cl);
    exp_t x;
    int   c   = mCnt[k];
    bit   t   = 1'b0;
    bit   sat = 1'b0;
    rst = '0; en = '0; load = '0; clrOvf = '0;
    rst[k] = r; en[k] = e; dir[k] = d; load[k] = l; loadVal[k] = 8'(lv); clrOvf[k] = cl;
    if (r) begin
      c = rstVal[k];
      mOvf[k] = 1'b0;
    end else begin
      if (l) c = (lv > maxVal[k]) ? maxVal[k] : lv;
      else if (e && d) begin
        if (c < maxVal[k]) c = c + 1;
        else if (modeV[k] == MODE_SAT) sat = 1'b1;
        else begin c = 0; t = 1'b1; end
      end else if (e) begin
        if (c > 0) c = c - 1;
        else if (modeV[k] == MODE_SAT) sat = 1'b1;
        else begin c = maxVal[k]; t = 1'b1; end
      end
      mOvf[k] = sat ? 1'b1 : (cl ? 1'b0 : mOvf[k]);
    end
    mCnt[k]  = c;
    x.inst   = k;
    x.cnt    = 8'(c);
    x.tc     = t;
    x.ovf    = mOvf[k];
    x.atMax  = (c == maxVal[k]);
    x.atZero = (c == 0);
    sbq.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic countSteps(input int k, input int n, input bit e, input bit d);
    for (int i = 0; i < n; i++) applyStimulus(k, 1'b0, e, d, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst = '1; en = '0; dir = '0; load = '0; clrOvf = '0;
    for (int i = 0; i < 3; i++) begin
      loadVal[i] = '0;
      mCnt[i]    = rstVal[i];
      mOvf[i]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // 8-bit wrap: full cycle up with tc on the roll-over, then down from reset
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    countSteps(0, 257, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    countSteps(0, 4, 1'b1, 1'b0);

    // 4-bit wrap at 9: wraps, clamped load, priority, back-to-back wraps
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    countSteps(1, 22, 1'b1, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b1, 15, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b0, 1'b1, i[0] == 1'b0 ? 1'b0 : 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    countSteps(1, 5, 1'b0, 1'b1);

    // 4-bit saturate at 9: clamp both ends, clr_ovf, set-wins, hold, dir toggle, reset
    applyStimulus(2, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    countSteps(2, 10, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    countSteps(2, 10, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    countSteps(2, 10, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    countSteps(2, 5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(2, 1'b0, 1'b1, i[0] == 1'b0 ? 1'b1 : 1'b0, 1'b0, 0, 1'b0);
    countSteps(2, 8, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 1'b1, 1'b1, 9, 1'b0);
    countSteps(2, 2, 1'b1, 1'b1);

    $monitoroff;
    if (sbq.size() != 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL scoreboard leftover observed=%0d expected=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
